// File: rtl/yadmc_toggle_resp.sv
// Toggle-handshake responder: turns each req_toggle change from a foreign domain
// into a local valid/ready command, then returns the local response with an ack_toggle change.
module yadmc_toggle_resp #(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_toggle,
    input  logic [DW-1:0] req_data,
    output logic          ack_toggle,
    output logic [DW-1:0] rsp_data,
    output logic          cmd_valid,
    output logic [DW-1:0] cmd_data,
    input  logic          cmd_ready,
    input  logic          done,
    input  logic [DW-1:0] rsp_in,
    output logic          overrun,
    input  logic          overrun_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VALID     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES:0] sync_q, sync_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [DW-1:0]        cmd_data_q, cmd_data_d;
    logic [DW-1:0]        rsp_data_q, rsp_data_d;
    logic                 ack_q, ack_d;
    logic                 overrun_q, overrun_d;
    logic                 req_edge_c;

    // Only sync_q[0] sees the asynchronous level; the top two stages form the edge detector.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-1:0], req_toggle};
    end

    assign req_edge_c = sync_q[SYNC_STAGES] ^ sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        rsp_data_d  = rsp_data_q;
        ack_d       = ack_q;
        overrun_d   = overrun_q;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_edge_c) begin
                    state_d     = VALID;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = req_data;
                end
            end
            VALID: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d     = WAIT_DONE;
                    cmd_valid_d = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    rsp_data_d = rsp_in;
                    state_d    = ACK;
                end
            end
            ACK: begin
                ack_d   = ~ack_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request arriving mid-transaction is dropped; detection beats a same-cycle clear.
        if (req_edge_c && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            rsp_data_q  <= '0;
            ack_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            rsp_data_q  <= rsp_data_d;
            ack_q       <= ack_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ack_toggle = ack_q;
    assign rsp_data   = rsp_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_yadmc_toggle_resp.sv
// Directed/randomized bench for yadmc_toggle_resp (2- and 3-stage synchronizer instances).
module tb_yadmc_toggle_resp;

    localparam int unsigned DW = 32;
    localparam int unsigned S2 = 2;
    localparam int unsigned S3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_toggle, cmd_ready, done, overrun_clr;
    logic [DW-1:0] req_data, rsp_in;
    logic          ack_toggle, cmd_valid, overrun;
    logic [DW-1:0] rsp_data, cmd_data;

    logic          b_req_toggle, b_cmd_ready, b_done, b_overrun_clr;
    logic [DW-1:0] b_req_data, b_rsp_in;
    logic          b_ack_toggle, b_cmd_valid, b_overrun;
    logic [DW-1:0] b_rsp_data, b_cmd_data;

    int   total = 0;
    int   bad   = 0;
    logic exp_ack;
    logic exp_ovr;

    yadmc_toggle_resp #(.DW(DW), .SYNC_STAGES(S2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_toggle(req_toggle), .req_data(req_data),
        .ack_toggle(ack_toggle), .rsp_data(rsp_data), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done(done), .rsp_in(rsp_in),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    yadmc_toggle_resp #(.DW(DW), .SYNC_STAGES(S3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_toggle(b_req_toggle), .req_data(b_req_data),
        .ack_toggle(b_ack_toggle), .rsp_data(b_rsp_data), .cmd_valid(b_cmd_valid),
        .cmd_data(b_cmd_data), .cmd_ready(b_cmd_ready), .done(b_done), .rsp_in(b_rsp_in),
        .overrun(b_overrun), .overrun_clr(b_overrun_clr)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [DW-1:0] d);
        req_data   = d;
        req_toggle = ~req_toggle;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while ((cmd_valid !== 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
    endtask

    // One complete initiator/consumer exchange against the transaction-level expectations.
    task automatic run_txn(input logic [DW-1:0] d, input int rdy_dly, input int done_dly,
                           input logic [DW-1:0] rsp, input logic done_with_accept);
        int   n;
        logic hold_ok;
        start_req(d);
        wait_valid(n);
        chk("cmd_valid_up", {31'd0, cmd_valid}, 32'd1);
        chk("latency", DW'(n), DW'(S2 + 1));
        chk("cmd_data", cmd_data, d);
        hold_ok = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            if ((cmd_valid !== 1'b1) || (cmd_data !== d)) hold_ok = 1'b0;
        end
        chk("cmd_hold", {31'd0, hold_ok}, 32'd1);
        cmd_ready = 1'b1;
        done      = done_with_accept;
        rsp_in    = ~rsp;
        tick();
        cmd_ready = 1'b0;
        done      = 1'b0;
        chk("accept_drop", {31'd0, cmd_valid}, 32'd0);
        for (int i = 0; i < done_dly; i++) tick();
        chk("ack_hold", {31'd0, ack_toggle}, {31'd0, exp_ack});
        rsp_in = rsp;
        done   = 1'b1;
        tick();
        done   = 1'b0;
        rsp_in = $urandom;
        chk("rsp_data", rsp_data, rsp);
        chk("ack_pre", {31'd0, ack_toggle}, {31'd0, exp_ack});
        tick();
        exp_ack = ~exp_ack;
        chk("ack_toggle", {31'd0, ack_toggle}, {31'd0, exp_ack});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            changes;
        logic          seen;
        logic          prev;
        logic [DW-1:0] d;
        logic [DW-1:0] r;

        rst_n = 1'b0;
        req_toggle = 1'b0; req_data = '0; cmd_ready = 1'b0; done = 1'b0;
        rsp_in = '0; overrun_clr = 1'b0;
        b_req_toggle = 1'b0; b_req_data = '0; b_cmd_ready = 1'b0; b_done = 1'b0;
        b_rsp_in = '0; b_overrun_clr = 1'b0;
        exp_ack = 1'b0;
        exp_ovr = 1'b0;

        #12;
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_ack", {31'd0, ack_toggle}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_cmd_data", cmd_data, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stray consumer strobes while idle must do nothing.
        cmd_ready = 1'b1; done = 1'b1; rsp_in = 32'hDEAD_BEEF;
        repeat (4) tick();
        cmd_ready = 1'b0; done = 1'b0;
        chk("idle_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("idle_ack", {31'd0, ack_toggle}, 32'd0);
        chk("idle_rsp", rsp_data, 32'd0);

        run_txn(32'hA5A5_0001, 0, 0, 32'h0000_1234, 1'b0);

        for (int i = 0; i < 3; i++) begin
            run_txn($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 4; i++) begin
            run_txn($urandom, 5, 1, $urandom, 1'b0);
        end
        chk("b2b_ack_end", {31'd0, ack_toggle}, 32'd0);
        chk("b2b_overrun", {31'd0, overrun}, 32'd0);

        // Second request while waiting for done.
        d = $urandom;
        start_req(d);
        wait_valid(n);
        chk("ovr_valid", {31'd0, cmd_valid}, 32'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        start_req(~d);
        repeat (S2 + 2) tick();
        exp_ovr = 1'b1;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        r = $urandom;
        rsp_in = r; done = 1'b1;
        tick();
        done = 1'b0;
        chk("ovr_rsp", rsp_data, r);
        prev = ack_toggle; changes = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_toggle !== prev) changes++;
            prev = ack_toggle;
            if (cmd_valid !== 1'b0) seen = 1'b1;
        end
        exp_ack = ~exp_ack;
        chk("ovr_ack_changes", DW'(changes), 32'd1);
        chk("ovr_no_extra_valid", {31'd0, seen}, 32'd0);
        chk("ovr_ack", {31'd0, ack_toggle}, {31'd0, exp_ack});
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        // Clear in the same cycle the overrun is detected: set wins.
        d = $urandom;
        start_req(d);
        wait_valid(n);
        chk("sim_valid", {31'd0, cmd_valid}, 32'd1);
        start_req(~d);
        repeat (S2) tick();
        chk("sim_pre", {31'd0, overrun}, 32'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("sim_ovr", {31'd0, overrun}, 32'd1);
        chk("sim_hold_valid", {31'd0, cmd_valid}, 32'd1);
        chk("sim_hold_data", cmd_data, d);

        // Asynchronous reset while a command is pending.
        chk("pre_rst_ack", {31'd0, ack_toggle}, {31'd0, exp_ack});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("arst_ack", {31'd0, ack_toggle}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        chk("arst_cmd_data", cmd_data, 32'd0);
        req_toggle = 1'b0; req_data = '0;
        exp_ack = 1'b0; exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid !== 1'b0) seen = 1'b1;
        end
        chk("post_rst_no_valid", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn($urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        // Three-stage synchronizer: one extra edge of latency.
        b_req_data = 32'hA5A5_0001;
        b_req_toggle = 1'b1;
        n = 0;
        while ((b_cmd_valid !== 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
        chk("s3_latency", DW'(n), DW'(S3 + 1));
        chk("s3_cmd_data", b_cmd_data, 32'hA5A5_0001);
        b_cmd_ready = 1'b1;
        tick();
        b_cmd_ready = 1'b0;
        b_rsp_in = 32'h0000_1234; b_done = 1'b1;
        tick();
        b_done = 1'b0;
        chk("s3_rsp", b_rsp_data, 32'h0000_1234);
        chk("s3_ack_pre", {31'd0, b_ack_toggle}, 32'd0);
        tick();
        chk("s3_ack", {31'd0, b_ack_toggle}, 32'd1);
        chk("s3_overrun", {31'd0, b_overrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
